// File: rtl/vga_plot_arbiter.sv
// Four-way round-robin arbiter for a single VGA pixel write port.
// The owner streams pixels until it signals last, hits BURST_LIMIT or drops its request.
module vga_plot_arbiter #(
  parameter int unsigned BURST_LIMIT = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [3:0]  valid,
  input  logic [3:0]  last,
  input  logic [31:0] x_in,
  input  logic [27:0] y_in,
  input  logic [11:0] col_in,
  output logic [3:0]  grant,
  output logic [3:0]  ready,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e      r_state, w_state_next;
  logic [1:0]  r_owner, w_owner_next;
  logic [1:0]  r_rr_ptr, w_rr_ptr_next;
  logic [1:0]  w_sel;
  logic [16:0] r_count, w_count_next;
  logic        w_accept, w_limit, w_release;
  logic [7:0]  w_x;
  logic [6:0]  w_y;
  logic [2:0]  w_col;

  // Walk offsets high to low so the lowest offset from rr_ptr wins.
  always_comb begin
    logic [1:0] idx;
    w_sel = r_rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = r_rr_ptr + 2'(k);
      if (req[idx]) w_sel = idx;
    end
  end

  assign busy     = (r_state == StGrant);
  assign grant    = busy ? (4'b0001 << r_owner) : 4'b0000;
  assign ready    = (busy && !reset) ? (grant & valid & req) : 4'b0000;
  assign w_accept = |ready;
  assign w_limit  = (r_count + 17'd1) == 17'(BURST_LIMIT);
  assign w_release = busy && (!req[r_owner] || (w_accept && (last[r_owner] || w_limit)));

  always_comb begin
    w_x   = x_in[7:0];
    w_y   = y_in[6:0];
    w_col = col_in[2:0];
    unique case (r_owner)
      2'd0: begin w_x = x_in[7:0];   w_y = y_in[6:0];   w_col = col_in[2:0];  end
      2'd1: begin w_x = x_in[15:8];  w_y = y_in[13:7];  w_col = col_in[5:3];  end
      2'd2: begin w_x = x_in[23:16]; w_y = y_in[20:14]; w_col = col_in[8:6];  end
      2'd3: begin w_x = x_in[31:24]; w_y = y_in[27:21]; w_col = col_in[11:9]; end
      default: ;
    endcase
  end

  always_comb begin
    w_state_next  = r_state;
    w_owner_next  = r_owner;
    w_rr_ptr_next = r_rr_ptr;
    w_count_next  = r_count;
    unique case (r_state)
      StIdle: begin
        if (|req) begin
          w_state_next = StGrant;
          w_owner_next = w_sel;
          w_count_next = 17'd0;
        end
      end
      StGrant: begin
        if (w_accept && r_count != 17'h1ffff) w_count_next = r_count + 17'd1;
        if (w_release) begin
          w_state_next  = StIdle;
          w_rr_ptr_next = r_owner + 2'd1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= StIdle;
      r_owner  <= 2'd0;
      r_rr_ptr <= 2'd0;
      r_count  <= 17'd0;
      plot     <= 1'b0;
      x        <= 8'd0;
      y        <= 7'd0;
      colour   <= 3'd0;
    end else begin
      r_state  <= w_state_next;
      r_owner  <= w_owner_next;
      r_rr_ptr <= w_rr_ptr_next;
      r_count  <= w_count_next;
      plot     <= w_accept;
      if (w_accept) begin
        x      <= w_x;
        y      <= w_y;
        colour <= w_col;
      end
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter with BURST_LIMIT = 4.
module tb_vga_plot_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0, valid = '0, last = '0;
  logic [31:0] x_in = '0;
  logic [27:0] y_in = '0;
  logic [11:0] col_in = '0;
  logic [3:0]  grant, ready;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, busy;

  int n_total = 0;
  int n_bad   = 0;

  logic [3:0] gexp_b [9] = '{4'd1, 4'd0, 4'd2, 4'd0, 4'd4, 4'd0, 4'd8, 4'd0, 4'd1};
  logic [3:0] gexp_c [6] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd2};
  logic       pexp_c [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  vga_plot_arbiter #(.BURST_LIMIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .valid (valid),
    .last  (last),
    .x_in  (x_in),
    .y_in  (y_in),
    .col_in(col_in),
    .grant (grant),
    .ready (ready),
    .x     (x),
    .y     (y),
    .colour(colour),
    .plot  (plot),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench at cycle 0: reset just released, registers cleared.
  task automatic do_reset();
    reset = 1'b1;
    req = '0; valid = '0; last = '0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state, with a requester already asking
    reset = 1'b1; req = 4'b0001; valid = 4'b0001;
    tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_plot", 32'(plot), 0);
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_col", 32'(colour), 0);
    chk("rst_busy", 32'(busy), 0);

    // Three-pixel burst from requester 0
    reset = 1'b0;
    x_in = {24'd0, 8'd10}; y_in = {21'd0, 7'd20}; col_in = {9'd0, 3'd3};
    #1 chk("a_c0_grant", 32'(grant), 0);
    tick();
    chk("a_c1_grant", 32'(grant), 1);
    chk("a_c1_ready", 32'(ready), 1);
    chk("a_c1_plot", 32'(plot), 0);
    tick();
    chk("a_c2_plot", 32'(plot), 1);
    chk("a_c2_x", 32'(x), 10);
    chk("a_c2_y", 32'(y), 20);
    chk("a_c2_col", 32'(colour), 3);
    tick();
    last = 4'b0001;
    #1 chk("a_c3_ready", 32'(ready), 1);
    chk("a_c3_plot", 32'(plot), 1);
    tick();
    req = '0; valid = '0; last = '0;
    #1 chk("a_c4_grant", 32'(grant), 0);
    chk("a_c4_plot", 32'(plot), 1);
    chk("a_c4_busy", 32'(busy), 0);
    tick();
    chk("a_c5_plot", 32'(plot), 0);
    chk("a_c5_x_hold", 32'(x), 10);

    // All four requesting, single-pixel bursts: strict rotation with dead cycles
    do_reset();
    req = 4'b1111; valid = 4'b1111; last = 4'b1111;
    x_in = {8'd40, 8'd30, 8'd20, 8'd10};
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk($sformatf("b_c%0d_grant", c), 32'(grant), 32'(gexp_b[c-1]));
      if (c % 2 == 0) begin
        chk($sformatf("b_c%0d_plot", c), 32'(plot), 1);
        chk($sformatf("b_c%0d_x", c), 32'(x), 32'(10 * (c / 2)));
      end
    end

    // Burst limit of 4 forces rotation from 0 to 1
    do_reset();
    req = 4'b0011; valid = 4'b0011; last = '0;
    x_in = {16'd0, 8'd77, 8'd5};
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk($sformatf("c_c%0d_grant", c), 32'(grant), 32'(gexp_c[c-1]));
      chk($sformatf("c_c%0d_plot", c), 32'(plot), 32'(pexp_c[c-1]));
      if (c == 2) chk("c_c2_ready", 32'(ready), 1);
    end
    chk("c_c6_ready", 32'(ready), 2);
    tick();
    chk("c_c7_x", 32'(x), 77);

    // Owner 2 drops req mid-burst; requester 3 is next
    do_reset();
    req = 4'b0100; valid = 4'b0100;
    x_in = {8'd0, 8'd66, 16'd0};
    tick();
    chk("d_c1_grant", 32'(grant), 4);
    tick();
    req = 4'b1000;
    #1 chk("d_c2_ready", 32'(ready), 0);
    chk("d_c2_plot", 32'(plot), 1);
    tick();
    chk("d_c3_grant", 32'(grant), 0);
    chk("d_c3_plot", 32'(plot), 0);
    chk("d_c3_x_hold", 32'(x), 66);
    tick();
    chk("d_c4_grant", 32'(grant), 8);

    // Same drop, 3 not requesting: search wraps to 0
    do_reset();
    req = 4'b0100; valid = 4'b0100;
    tick();
    tick();
    req = 4'b0011;
    #1 chk("d2_c2_ready", 32'(ready), 0);
    tick();
    chk("d2_c3_grant", 32'(grant), 0);
    tick();
    chk("d2_c4_grant", 32'(grant), 1);

    // Reset during requester 1's burst
    do_reset();
    req = 4'b0010; valid = 4'b0010;
    x_in = {16'd0, 8'd99, 8'd0}; y_in = {14'd0, 7'd55, 7'd0}; col_in = {6'd0, 3'd6, 3'd0};
    tick();
    chk("e_c1_grant", 32'(grant), 2);
    tick();
    chk("e_c2_x", 32'(x), 99);
    reset = 1'b1;
    #1 chk("e_c2_ready_rst", 32'(ready), 0);
    tick();
    reset = 1'b0;
    chk("e_c3_grant", 32'(grant), 0);
    chk("e_c3_plot", 32'(plot), 0);
    chk("e_c3_x", 32'(x), 0);
    chk("e_c3_y", 32'(y), 0);
    chk("e_c3_col", 32'(colour), 0);
    tick();
    chk("e_c4_grant", 32'(grant), 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
